// File: rtl/countdown_digit_scan.sv
// MM:SS BCD countdown timer with a free-running 4-digit display scan.
// Digit feeds a registered 7-seg decoder; anode is delayed one extra cycle to match it.
module countdown_digit_scan #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  Digit,
  output logic [3:0]  anode,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        load_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [TW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;
  logic [SW-1:0] sctr_q, sctr_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    anode_pre_q, anode_pre_d;
  logic [3:0]    anode_q, anode_d;
  logic          load_ok;

  // One-second BCD decrement with sec10 borrowing to 5 (minutes roll at 60).
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign load_ok = (load_value[15:12] <= 4'd9) && (load_value[11:8] <= 4'd9) &&
                   (load_value[7:4]   <= 4'd5) && (load_value[3:0]  <= 4'd9);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_value;
        presc_d = '0;
        state_d = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start && state_q == IDLE) begin
      presc_d = '0;
      if (count_q == 16'h0000) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (start && state_q == PAUSED) begin
      state_d = RUN;
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (state_q == RUN) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        count_d = bcd_dec(count_q);
        if (count_q == 16'h0001) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + TW'(1);
      end
    end
    running_d = (state_d == RUN);
  end

  always_comb begin
    sctr_d      = sctr_q + SW'(1);
    idx_d       = idx_q;
    if (sctr_q == SCAN_LAST) begin
      sctr_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    digit_d     = 4'(count_q >> {idx_q, 2'b00});
    anode_pre_d = ~(4'b0001 << idx_q);
    anode_d     = anode_pre_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 16'h0000;
      presc_q     <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
      sctr_q      <= '0;
      idx_q       <= 2'd0;
      digit_q     <= 4'd0;
      anode_pre_q <= 4'b1111;
      anode_q     <= 4'b1111;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      running_q   <= running_d;
      done_q      <= done_d;
      load_err_q  <= load_err_d;
      sctr_q      <= sctr_d;
      idx_q       <= idx_d;
      digit_q     <= digit_d;
      anode_pre_q <= anode_pre_d;
      anode_q     <= anode_d;
    end
  end

  assign Digit    = digit_q;
  assign anode    = anode_q;
  assign count    = count_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule
